// File: rtl/cpu_regfile_sb.sv
// cpu_regfile_sb: moxie register file with two registered read ports, one
// write port, optional write-to-read bypass and a pending-write scoreboard.
// Decode reads and reserves destination registers; writeback writes them and
// clears their pending bit.
module cpu_regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int BYPASS     = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          rd_en_i,
  input  logic [ADDR_WIDTH-1:0]         rd_idx1_i,
  input  logic [ADDR_WIDTH-1:0]         rd_idx2_i,
  output logic [DATA_WIDTH-1:0]         rd_val1_o,
  output logic [DATA_WIDTH-1:0]         rd_val2_o,
  output logic                          rd_valid_o,
  output logic                          rd_busy1_o,
  output logic                          rd_busy2_o,
  input  logic                          wr_en_i,
  input  logic [ADDR_WIDTH-1:0]         wr_idx_i,
  input  logic [DATA_WIDTH-1:0]         wr_val_i,
  input  logic                          rsv_en_i,
  input  logic [ADDR_WIDTH-1:0]         rsv_idx_i,
  output logic [(2**ADDR_WIDTH)-1:0]    busy_o
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rd_val1_q, rd_val1_d;
  logic [DATA_WIDTH-1:0] rd_val2_q, rd_val2_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_busy1_q, rd_busy1_d;
  logic                  rd_busy2_q, rd_busy2_d;

  logic byp1, byp2;

  // Next array contents and scoreboard: write clears, then reserve sets, so a
  // same-edge reserve (the newer instruction) wins over the older write.
  always_comb begin
    // NOTE: every signal gets a default at the top of always_comb; a path that
    // leaves one unassigned would infer a latch.
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_en_i) begin
      regs_d[wr_idx_i] = wr_val_i;
      busy_d[wr_idx_i] = 1'b0;
    end
    if (rsv_en_i) begin
      busy_d[rsv_idx_i] = 1'b1;
    end
  end

  // Bypass hit per port: same-edge write to the index being read.
  always_comb begin
    byp1 = (BYPASS != 0) && wr_en_i && (rd_idx1_i == wr_idx_i);
    byp2 = (BYPASS != 0) && wr_en_i && (rd_idx2_i == wr_idx_i);
  end

  // Read ports: hold data and busy flags when idle; on a bypass hit the busy
  // flag reflects only a same-edge reserve, otherwise the pre-edge scoreboard.
  always_comb begin
    rd_val1_d  = rd_val1_q;
    rd_val2_d  = rd_val2_q;
    rd_busy1_d = rd_busy1_q;
    rd_busy2_d = rd_busy2_q;
    rd_valid_d = 1'b0;
    if (rd_en_i) begin
      rd_valid_d = 1'b1;
      if (byp1) begin
        rd_val1_d  = wr_val_i;
        rd_busy1_d = rsv_en_i && (rsv_idx_i == rd_idx1_i);
      end else begin
        rd_val1_d  = regs_q[rd_idx1_i];
        rd_busy1_d = busy_q[rd_idx1_i];
      end
      if (byp2) begin
        rd_val2_d  = wr_val_i;
        rd_busy2_d = rsv_en_i && (rsv_idx_i == rd_idx2_i);
      end else begin
        rd_val2_d  = regs_q[rd_idx2_i];
        rd_busy2_d = busy_q[rd_idx2_i];
      end
    end
  end

  // State registers; reset clears everything, including the register array.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the array is reset here because software relies on registers
      // reading as zero after reset; a plain RAM without reset would not.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      rd_val1_q  <= '0;
      rd_val2_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_busy1_q <= 1'b0;
      rd_busy2_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before the edge, independent of statement order.
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      rd_val1_q  <= rd_val1_d;
      rd_val2_q  <= rd_val2_d;
      rd_valid_q <= rd_valid_d;
      rd_busy1_q <= rd_busy1_d;
      rd_busy2_q <= rd_busy2_d;
    end
  end

  assign rd_val1_o  = rd_val1_q;
  assign rd_val2_o  = rd_val2_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_busy1_o = rd_busy1_q;
  assign rd_busy2_o = rd_busy2_q;
  assign busy_o     = busy_q;

endmodule
